// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
// Conditional execution is enabled by defining ALU_SEQ_COND_EN.
package alu_seq_pkg;

  // Sequencer control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } seq_state_e;

  // Condition codes carried on InstrCond
  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_CS = 3'd3;
  localparam logic [2:0] COND_CC = 3'd4;
  localparam logic [2:0] COND_MI = 3'd5;
  localparam logic [2:0] COND_PL = 3'd6;
  localparam logic [2:0] COND_VS = 3'd7;

  // Bit positions inside the ALU flag word {Z, C, N, O}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  // Evaluates a condition code against a flag word; unknown codes never pass
  function automatic logic cond_check(input logic [2:0] cond, input logic [3:0] flags);
    logic pass_v;
    case (cond)
      COND_AL: pass_v = 1'b1;
      COND_EQ: pass_v = flags[FLAG_Z];
      COND_NE: pass_v = ~flags[FLAG_Z];
      COND_CS: pass_v = flags[FLAG_C];
      COND_CC: pass_v = ~flags[FLAG_C];
      COND_MI: pass_v = flags[FLAG_N];
      COND_PL: pass_v = ~flags[FLAG_N];
      COND_VS: pass_v = flags[FLAG_O];
      default: pass_v = 1'b0;
    endcase
    return pass_v;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction, result and ALU-side signals of the ALU operation sequencer.
// master = the sequencer, slave = decode path / consumer / ALU side.
interface alu_op_sequencer_if;
  logic        InstrValid;
  logic        InstrReady;
  logic [3:0]  InstrOp;
  logic        InstrSize;
  logic        InstrSetFlags;
  logic [2:0]  InstrCond;
  logic [4:0]  FunSel;
  logic        WF;
  logic [15:0] ALUOut;
  logic [3:0]  FlagsOut;
  logic        ResultValid;
  logic        ResultReady;
  logic [15:0] Result;
  logic [3:0]  ResultFlags;
  logic        ResultExecuted;

  modport master (
    input  InstrValid, InstrOp, InstrSize, InstrSetFlags, InstrCond,
    input  ALUOut, FlagsOut, ResultReady,
    output InstrReady, FunSel, WF, ResultValid, Result, ResultFlags, ResultExecuted
  );

  modport slave (
    output InstrValid, InstrOp, InstrSize, InstrSetFlags, InstrCond,
    output ALUOut, FlagsOut, ResultReady,
    input  InstrReady, FunSel, WF, ResultValid, Result, ResultFlags, ResultExecuted
  );
endinterface

// File: rtl/alu_cond_eval.sv
// Combinational condition evaluator: (condition code, ALU flags) -> pass.
// Only instantiated when ALU_SEQ_COND_EN is defined.
module alu_cond_eval
  import alu_seq_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       cond_pass
);

  // Decode the condition code against the live flag word
  always_comb begin
    cond_pass = cond_check(cond, flags);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one instruction, optionally gates it on
// the ALU's current flags, drives FunSel/WF for one execute cycle, captures
// ALUOut and the updated flags, and returns them over a result handshake.
// Build option: ALU_SEQ_COND_EN enables conditional execution; when it is
// undefined every instruction executes and InstrCond is ignored.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset,
  alu_op_sequencer_if.master    bus
);

  seq_state_e  state_r, state_n;
  logic [4:0]  fun_sel_r, fun_sel_n;
  logic        wf_r, wf_n;
  logic [15:0] result_r, result_n;
  logic [3:0]  result_flags_r, result_flags_n;
  logic        result_exec_r, result_exec_n;
  logic        result_valid_r, result_valid_n;
  logic        accept_s;

`ifdef ALU_SEQ_COND_EN
  logic        cond_pass_s;

  alu_cond_eval u_cond_eval (
    .cond      (bus.InstrCond),
    .flags     (bus.FlagsOut),
    .cond_pass (cond_pass_s)
  );
`endif

  assign accept_s = (state_r == IDLE) && bus.InstrValid;

  // Next-state and next-output logic; FunSel/WF registers double as the
  // latched instruction fields so a skipped instruction never disturbs them
  always_comb begin
    state_n        = state_r;
    fun_sel_n      = fun_sel_r;
    wf_n           = 1'b0;
    result_n       = result_r;
    result_flags_n = result_flags_r;
    result_exec_n  = result_exec_r;
    result_valid_n = result_valid_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
`ifdef ALU_SEQ_COND_EN
          if (cond_pass_s) begin
            state_n   = ISSUE;
            fun_sel_n = {bus.InstrSize, bus.InstrOp};
            wf_n      = bus.InstrSetFlags;
          end else begin
            state_n        = RESP;
            result_n       = 16'h0000;
            result_flags_n = bus.FlagsOut;
            result_exec_n  = 1'b0;
            result_valid_n = 1'b1;
          end
`else
          state_n   = ISSUE;
          fun_sel_n = {bus.InstrSize, bus.InstrOp};
          wf_n      = bus.InstrSetFlags;
`endif
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        result_n = bus.ALUOut;
        state_n  = SETTLE;
      end
      SETTLE: begin
        result_flags_n = bus.FlagsOut;
        result_exec_n  = 1'b1;
        result_valid_n = 1'b1;
        state_n        = RESP;
      end
      RESP: begin
        if (bus.ResultReady) begin
          result_valid_n = 1'b0;
          state_n        = IDLE;
        end else begin
          state_n = RESP;
        end
      end
      default: begin
        state_n        = IDLE;
        result_valid_n = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; an in-flight instruction is dropped
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Output/datapath registers; WF clears on the reset edge so no flag write follows
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fun_sel_r      <= 5'b00000;
      wf_r           <= 1'b0;
      result_r       <= 16'h0000;
      result_flags_r <= 4'h0;
      result_exec_r  <= 1'b0;
      result_valid_r <= 1'b0;
    end else begin
      fun_sel_r      <= fun_sel_n;
      wf_r           <= wf_n;
      result_r       <= result_n;
      result_flags_r <= result_flags_n;
      result_exec_r  <= result_exec_n;
      result_valid_r <= result_valid_n;
    end
  end

  // Ready is gated by Reset so it is low for the whole reset window
  assign bus.InstrReady     = (state_r == IDLE) && !Reset;
  assign bus.FunSel         = fun_sel_r;
  assign bus.WF             = wf_r;
  assign bus.Result         = result_r;
  assign bus.ResultFlags    = result_flags_r;
  assign bus.ResultExecuted = result_exec_r;
  assign bus.ResultValid    = result_valid_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a small behavioural ALU and
// an instruction-level reference model. Honours ALU_SEQ_COND_EN.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] op_a, op_b;
  logic [3:0]  alu_flags_r = 4'h0;
  logic [19:0] alu_word;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [3:0]  mdl_flags = 4'h0;
  logic [4:0]  mdl_funsel = 5'b00000;
  logic [15:0] obs_res;
  logic [3:0]  obs_flg;
  logic        obs_exec;

  alu_op_sequencer_if bus ();

  alu_op_sequencer dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural 16-bit ALU: {Z,C,N,O,result}; 8-bit ops work on low bytes and
  // pass the upper byte of A through
  function automatic logic [19:0] alu_calc(input logic [4:0] fs, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, r;
    logic [16:0] w;
    logic c, o;
    x = fs[4] ? a : {a[7:0], 8'h00};
    y = fs[4] ? b : {b[7:0], 8'h00};
    c = 1'b0;
    o = 1'b0;
    w = 17'd0;
    case (fs[3:0])
      4'h4: begin
        w = {1'b0, x} + {1'b0, y};
        r = w[15:0]; c = w[16];
        o = (x[15] == y[15]) && (r[15] != x[15]);
      end
      4'h5: begin
        w = {1'b0, x} + {1'b0, ~y} + 17'd1;
        r = w[15:0]; c = w[16];
        o = (x[15] != y[15]) && (r[15] != x[15]);
      end
      4'h7: r = x & y;
      default: r = x ^ y;
    endcase
    return {(r == 16'h0000), c, r[15], o, (fs[4] ? r : {a[15:8], r[15:8]})};
  endfunction

  // Reference condition rule on flags {Z,C,N,O}
  function automatic logic ref_cond(input logic [2:0] c, input logic [3:0] f);
    logic [7:0] table_v;
    logic       r;
    table_v = {f[0], ~f[1], f[1], ~f[2], f[2], ~f[3], f[3], 1'b1};
    r = table_v[c];
`ifndef ALU_SEQ_COND_EN
    r = 1'b1;
`endif
    return r;
  endfunction

  assign alu_word     = alu_calc(bus.FunSel, op_a, op_b);
  assign bus.ALUOut   = alu_word[15:0];
  assign bus.FlagsOut = alu_flags_r;

  // ALU flag register written on WF
  always @(posedge clk) begin
    if (bus.WF) alu_flags_r <= alu_word[19:16];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction through the full handshake with `hold` cycles of back-pressure
  task automatic run_instr(input logic [3:0] op, input logic size, input logic sf,
                           input logic [2:0] cond, input logic [15:0] a, input logic [15:0] b,
                           input int hold);
    logic        pass;
    logic [19:0] calc;
    logic [15:0] exp_res;
    logic [3:0]  exp_flg;
    logic        exp_exec;
    op_a = a; op_b = b;
    bus.InstrOp = op; bus.InstrSize = size; bus.InstrSetFlags = sf; bus.InstrCond = cond;
    bus.InstrValid = 1'b1;
    check_val("ready_idle", bus.InstrReady, 1);
    check_val("alu_flags", bus.FlagsOut, mdl_flags);
    pass = ref_cond(cond, mdl_flags);
    calc = alu_calc({size, op}, a, b);
    tick();
    bus.InstrValid = 1'b0;
    if (pass) begin
      check_val("wf_issue", bus.WF, sf);
      check_val("funsel_issue", bus.FunSel, {size, op});
      check_val("valid_issue", bus.ResultValid, 0);
      check_val("ready_busy", bus.InstrReady, 0);
      tick();
      check_val("wf_settle", bus.WF, 0);
      check_val("funsel_settle", bus.FunSel, {size, op});
      check_val("valid_settle", bus.ResultValid, 0);
      if (sf) mdl_flags = calc[19:16];
      mdl_funsel = {size, op};
      tick();
      exp_res = calc[15:0]; exp_flg = mdl_flags; exp_exec = 1'b1;
    end else begin
      check_val("wf_skip", bus.WF, 0);
      check_val("funsel_skip", bus.FunSel, mdl_funsel);
      exp_res = 16'h0000; exp_flg = mdl_flags; exp_exec = 1'b0;
    end
    obs_res = bus.Result; obs_flg = bus.ResultFlags; obs_exec = bus.ResultExecuted;
    check_val("valid_resp", bus.ResultValid, 1);
    check_val("result", bus.Result, exp_res);
    check_val("result_flags", bus.ResultFlags, exp_flg);
    check_val("result_exec", bus.ResultExecuted, exp_exec);
    check_val("ready_resp", bus.InstrReady, 0);
    for (int h = 0; h < hold; h++) begin
      bus.ResultReady = 1'b0;
      bus.InstrValid = 1'b1;
      tick();
      check_val("hold_valid", bus.ResultValid, 1);
      check_val("hold_result", bus.Result, exp_res);
      check_val("hold_flags", bus.ResultFlags, exp_flg);
      check_val("hold_exec", bus.ResultExecuted, exp_exec);
      check_val("hold_ready", bus.InstrReady, 0);
    end
    bus.InstrValid = 1'b0;
    bus.ResultReady = 1'b1;
    tick();
    bus.ResultReady = 1'b0;
    check_val("release_valid", bus.ResultValid, 0);
    check_val("release_ready", bus.InstrReady, 1);
  endtask

  logic [3:0] op_tab [4] = '{4'h4, 4'h5, 4'h7, 4'h2};

  initial begin
    int         n_acc, last_acc, exp_gap;
    logic       wf_prev, acc_pass;
    logic [19:0] calc;

    rst = 1'b1;
    op_a = 16'h0000; op_b = 16'h0000;
    bus.InstrValid = 1'b0; bus.InstrOp = 4'h0; bus.InstrSize = 1'b0;
    bus.InstrSetFlags = 1'b0; bus.InstrCond = 3'd0; bus.ResultReady = 1'b0;
    repeat (3) tick();
    check_val("rst_ready", bus.InstrReady, 0);
    check_val("rst_wf", bus.WF, 0);
    check_val("rst_funsel", bus.FunSel, 0);
    check_val("rst_valid", bus.ResultValid, 0);
    check_val("rst_result", bus.Result, 0);
    check_val("rst_flags", bus.ResultFlags, 0);
    check_val("rst_exec", bus.ResultExecuted, 0);
    rst = 1'b0;
    #1;
    check_val("ready_after_rst", bus.InstrReady, 1);

    // ADD16 0x7FFF + 0x0001 with flags
    run_instr(4'b0100, 1'b1, 1'b1, 3'd0, 16'h7FFF, 16'h0001, 0);
    check_val("add16_result", obs_res, 16'h8000);
    check_val("add16_flags", obs_flg, 4'b0011);
    check_val("add16_exec", obs_exec, 1);

    // EQ with Z=0: skipped when conditional execution is built in
    run_instr(4'b0100, 1'b1, 1'b1, 3'd1, 16'h1234, 16'h1111, 0);
`ifdef ALU_SEQ_COND_EN
    check_val("eq_skip_exec", obs_exec, 0);
    check_val("eq_skip_result", obs_res, 0);
`else
    check_val("eq_exec_nocond", obs_exec, 1);
`endif

    // SUB16 5-3 leaves C=1, then CS executes; with back-pressure of 5 cycles
    run_instr(4'b0101, 1'b1, 1'b1, 3'd0, 16'h0005, 16'h0003, 0);
    check_val("sub_flags", obs_flg, 4'b0100);
    run_instr(4'b0111, 1'b1, 1'b0, 3'd3, 16'hF0F0, 16'h3C3C, 5);
    check_val("cs_exec", obs_exec, 1);
    check_val("cs_result", obs_res, 16'h3030);

    // 8-bit op: upper byte passes through unmasked
    run_instr(4'b0100, 1'b0, 1'b0, 3'd0, 16'hAB7F, 16'h0001, 1);
    check_val("add8_result", obs_res, 16'hAB80);

    // Reset during ISSUE drops the instruction
    op_a = 16'h4000; op_b = 16'h4000;
    bus.InstrOp = 4'h4; bus.InstrSize = 1'b1; bus.InstrSetFlags = 1'b1; bus.InstrCond = 3'd0;
    bus.InstrValid = 1'b1;
    calc = alu_calc(5'b10100, op_a, op_b);
    tick();
    bus.InstrValid = 1'b0;
    check_val("wf_pre_reset", bus.WF, 1);
    rst = 1'b1;
    tick();
    mdl_flags = calc[19:16];
    mdl_funsel = 5'b00000;
    check_val("rst_issue_wf", bus.WF, 0);
    check_val("rst_issue_funsel", bus.FunSel, 0);
    check_val("rst_issue_valid", bus.ResultValid, 0);
    rst = 1'b0;
    bus.ResultReady = 1'b1;
    #1;
    check_val("rst_issue_idle", bus.InstrReady, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("dropped_no_result", bus.ResultValid, 0);
    end
    bus.ResultReady = 1'b0;

    // Randomized instructions
    for (int i = 0; i < 40; i++) begin
      run_instr(op_tab[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), $urandom_range(0, 3));
    end

    // Back-to-back with ResultReady high: gap 4 executed, 2 skipped; WF never adjacent
    op_a = 16'($urandom); op_b = 16'($urandom);
    bus.ResultReady = 1'b1;
    n_acc = 0; last_acc = 0; exp_gap = 0; wf_prev = 1'b0;
    bus.InstrOp = op_tab[$urandom_range(0, 3)]; bus.InstrSize = 1'($urandom_range(0, 1));
    bus.InstrSetFlags = 1'b1; bus.InstrCond = 3'd0;
    bus.InstrValid = 1'b1;
    for (int cyc = 0; cyc < 200 && n_acc < 10; cyc++) begin
      check_val("wf_not_adjacent", bus.WF & wf_prev, 0);
      wf_prev = bus.WF;
      if (bus.InstrReady) begin
        check_val("b2b_flags", bus.FlagsOut, mdl_flags);
        acc_pass = ref_cond(bus.InstrCond, mdl_flags);
        if (n_acc > 0) check_val("b2b_interval", cyc - last_acc, exp_gap);
        exp_gap = acc_pass ? 4 : 2;
        calc = alu_calc({bus.InstrSize, bus.InstrOp}, op_a, op_b);
        if (acc_pass && bus.InstrSetFlags) mdl_flags = calc[19:16];
        if (acc_pass) mdl_funsel = {bus.InstrSize, bus.InstrOp};
        last_acc = cyc;
        n_acc++;
        tick();
        if (n_acc < 10) begin
          bus.InstrOp = op_tab[$urandom_range(0, 3)]; bus.InstrSize = 1'($urandom_range(0, 1));
          bus.InstrSetFlags = 1'($urandom_range(0, 1)); bus.InstrCond = 3'($urandom_range(0, 7));
        end else begin
          bus.InstrValid = 1'b0;
        end
      end else begin
        tick();
      end
    end
    check_val("b2b_count", n_acc, 10);
    bus.InstrValid = 1'b0;
    repeat (5) tick();
    bus.ResultReady = 1'b0;
    check_val("final_flags", bus.FlagsOut, mdl_flags);
    check_val("final_funsel", bus.FunSel, mdl_funsel);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
